// File: rtl/pipe_sequencer.sv
// Central sequencing controller for the fetch/decode/exec-dmem/writeback pipeline.
// Owns the PC, drives the stage enables and bubble strobes, and arbitrates stall causes.
module pipe_sequencer #(
  parameter int                 BIN_DIG      = 32,
  parameter logic [BIN_DIG-1:0] RESET_PC     = '0,
  parameter int                 DMEM_TIMEOUT = 15
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [4:0]         dec_rs1,
  input  logic [4:0]         dec_rs2,
  input  logic               dec_uses_rs2,
  input  logic               halt_req,
  input  logic [4:0]         ex_rd,
  input  logic               ex_is_load,
  input  logic               br_taken,
  input  logic [BIN_DIG-1:0] br_target,
  input  logic               dmem_req,
  input  logic               dmem_ack,
  output logic [BIN_DIG-1:0] pc,
  output logic               if_en,
  output logic               id_en,
  output logic               ex_en,
  output logic               wb_en,
  output logic               id_flush,
  output logic               ex_flush,
  output logic [1:0]         state,
  output logic               fault,
  output logic [15:0]        stall_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALTED   = 2'd3
  } state_t;

  // One action per cycle; HOLD covers IDLE/HALTED, FREEZE covers any memory stall.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_FREEZE,
    ACT_BRANCH,
    ACT_HALT,
    ACT_BUBBLE,
    ACT_STEP
  } act_t;

  localparam int                 WAIT_W     = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'((DMEM_TIMEOUT > 0) ? DMEM_TIMEOUT - 1 : 0);
  localparam bit                 TIMEOUT_ON = (DMEM_TIMEOUT != 0);
  localparam logic [BIN_DIG-1:0] ALIGN_MASK = BIN_DIG'(3);
  localparam logic [BIN_DIG-1:0] PC_STEP    = BIN_DIG'(4);

  state_t            state_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              dmem_stall;
  logic              stall_event;
  act_t              resolve_act;
  act_t              act;

  assign state = state_q;

  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((ex_rd == dec_rs1) || (dec_uses_rs2 && (ex_rd == dec_rs2)));

  assign dmem_stall = dmem_req && !dmem_ack;

  // Priority among the non-memory causes; the memory cause is layered on per state.
  always_comb begin
    if (br_taken)      resolve_act = ACT_BRANCH;
    else if (halt_req) resolve_act = ACT_HALT;
    else if (load_use) resolve_act = ACT_BUBBLE;
    else               resolve_act = ACT_STEP;
  end

  always_comb begin
    act = ACT_HOLD;
    unique case (state_q)
      RUN:      act = dmem_stall ? ACT_FREEZE : resolve_act;
      MEM_WAIT: act = dmem_ack ? resolve_act : ACT_FREEZE;
      default:  act = ACT_HOLD;
    endcase
  end

  always_comb begin
    if_en    = 1'b0;
    id_en    = 1'b0;
    ex_en    = 1'b0;
    wb_en    = 1'b0;
    id_flush = 1'b0;
    ex_flush = 1'b0;
    unique case (act)
      ACT_BRANCH: begin
        if_en    = 1'b1;
        id_en    = 1'b1;
        ex_en    = 1'b1;
        wb_en    = 1'b1;
        id_flush = 1'b1;
        ex_flush = 1'b1;
      end
      ACT_HALT, ACT_BUBBLE: begin
        ex_en    = 1'b1;
        wb_en    = 1'b1;
        ex_flush = 1'b1;
      end
      ACT_STEP: begin
        if_en = 1'b1;
        id_en = 1'b1;
        ex_en = 1'b1;
        wb_en = 1'b1;
      end
      default: ;
    endcase
  end

  // The drain cycle into HALTED is not counted as a stall.
  assign stall_event = ((state_q == RUN) || (state_q == MEM_WAIT)) && !if_en && (act != ACT_HALT);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      pc        <= RESET_PC;
      fault     <= 1'b0;
      stall_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (stall_event && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;

      unique case (state_q)
        IDLE: begin
          if (start) state_q <= RUN;
        end
        RUN, MEM_WAIT: begin
          unique case (act)
            ACT_FREEZE: begin
              if (state_q == RUN) begin
                state_q  <= MEM_WAIT;
                wait_cnt <= '0;
              end else begin
                if (wait_cnt != '1) wait_cnt <= wait_cnt + WAIT_W'(1);
                if (TIMEOUT_ON && (wait_cnt == WAIT_LAST)) begin
                  state_q <= HALTED;
                  fault   <= 1'b1;
                end
              end
            end
            ACT_BRANCH: begin
              pc      <= br_target & ~ALIGN_MASK;
              state_q <= RUN;
            end
            ACT_HALT:   state_q <= HALTED;
            ACT_BUBBLE: state_q <= RUN;
            ACT_STEP: begin
              pc      <= pc + PC_STEP;
              state_q <= RUN;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_sequencer.sv
// Bench for pipe_sequencer: directed scenarios followed by random traffic,
// each cycle compared against a cycle-level reference model of the sequencing rules.
module tb_pipe_sequencer;

  localparam int          TMO      = 15;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam int          S_IDLE   = 0;
  localparam int          S_RUN    = 1;
  localparam int          S_WAIT   = 2;
  localparam int          S_HALT   = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  dec_rs1 = '0;
  logic [4:0]  dec_rs2 = '0;
  logic        dec_uses_rs2 = 1'b0;
  logic        halt_req = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        ex_is_load = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        dmem_req = 1'b0;
  logic        dmem_ack = 1'b0;
  logic [31:0] pc;
  logic        if_en, id_en, ex_en, wb_en, id_flush, ex_flush;
  logic [1:0]  state;
  logic        fault;
  logic [15:0] stall_cnt;

  pipe_sequencer #(
    .BIN_DIG(32),
    .RESET_PC(RST_PC),
    .DMEM_TIMEOUT(TMO)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .start(start),
    .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2),
    .dec_uses_rs2(dec_uses_rs2),
    .halt_req(halt_req),
    .ex_rd(ex_rd),
    .ex_is_load(ex_is_load),
    .br_taken(br_taken),
    .br_target(br_target),
    .dmem_req(dmem_req),
    .dmem_ack(dmem_ack),
    .pc(pc),
    .if_en(if_en),
    .id_en(id_en),
    .ex_en(ex_en),
    .wb_en(wb_en),
    .id_flush(id_flush),
    .ex_flush(ex_flush),
    .state(state),
    .fault(fault),
    .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Reference model state
  int          m_state;
  logic [31:0] m_pc;
  logic        m_fault;
  int          m_stall;
  int          m_waits;   // consecutive MEM_WAIT cycles without ack so far

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // e = {if_en, id_en, ex_en, wb_en, id_flush, ex_flush}
  task automatic check_all(input logic [5:0] e);
    chk("if_en", {31'd0, if_en}, {31'd0, e[5]});
    chk("id_en", {31'd0, id_en}, {31'd0, e[4]});
    chk("ex_en", {31'd0, ex_en}, {31'd0, e[3]});
    chk("wb_en", {31'd0, wb_en}, {31'd0, e[2]});
    chk("id_flush", {31'd0, id_flush}, {31'd0, e[1]});
    chk("ex_flush", {31'd0, ex_flush}, {31'd0, e[0]});
    chk("pc", pc, m_pc);
    chk("state", {30'd0, state}, 32'(m_state));
    chk("fault", {31'd0, fault}, {31'd0, m_fault});
    chk("stall_cnt", {16'd0, stall_cnt}, 32'(m_stall));
  endtask

  task automatic clear_inputs();
    start = 0; dec_rs1 = 0; dec_rs2 = 0; dec_uses_rs2 = 0; halt_req = 0;
    ex_rd = 0; ex_is_load = 0; br_taken = 0; br_target = 0; dmem_req = 0; dmem_ack = 0;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic cycle();
    logic [5:0]  e;
    int          ns, nw, nst;
    logic [31:0] npc;
    logic        nf;
    bit          lu, halting;
    #1;
    e = 6'b0; ns = m_state; npc = m_pc; nf = m_fault; nw = m_waits; halting = 0;
    lu = ex_is_load && (ex_rd != 0) &&
         ((ex_rd == dec_rs1) || (dec_uses_rs2 && (ex_rd == dec_rs2)));
    if ((m_state == S_RUN) || (m_state == S_WAIT && dmem_ack)) begin
      if (m_state == S_RUN && dmem_req && !dmem_ack) begin
        ns = S_WAIT; nw = 0;
      end else if (br_taken) begin
        e = 6'b111111; npc = br_target & ~32'h3; ns = S_RUN;
      end else if (halt_req) begin
        e = 6'b001101; ns = S_HALT; halting = 1;
      end else if (lu) begin
        e = 6'b001101; ns = S_RUN;
      end else begin
        e = 6'b111100; npc = m_pc + 32'd4; ns = S_RUN;
      end
    end else if (m_state == S_WAIT) begin
      nw = m_waits + 1;
      if (TMO != 0 && nw == TMO) begin
        ns = S_HALT; nf = 1;
      end
    end else if (m_state == S_IDLE && start) begin
      ns = S_RUN;
    end
    nst = m_stall;
    if ((m_state == S_RUN || m_state == S_WAIT) && !e[5] && !halting && nst < 65535) nst++;
    check_all(e);
    @(posedge CLK);
    m_state = ns; m_pc = npc; m_fault = nf; m_waits = nw; m_stall = nst;
    @(negedge CLK);
  endtask

  // Asynchronous reset pulse mid-cycle; outputs must drop without a clock edge.
  task automatic do_reset();
    RST = 0;
    #1;
    m_state = S_IDLE; m_pc = RST_PC; m_fault = 0; m_stall = 0; m_waits = 0;
    check_all(6'b0);
    @(negedge CLK);
    RST = 1;
  endtask

  initial begin
    @(negedge CLK);
    do_reset();
    clear_inputs();

    // Reset / start
    cycle();
    start = 1; cycle(); start = 0;
    chk("start_state", {30'd0, state}, 32'd1);
    chk("start_pc", pc, 32'h0);
    repeat (3) cycle();
    chk("pc_after_3", pc, 32'h0000_000C);

    // Load-use, then same pattern with x0 destination
    ex_is_load = 1; ex_rd = 5; dec_rs1 = 5; cycle();
    chk("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    chk("lu_pc_held", pc, 32'h0000_000C);
    ex_rd = 0; dec_rs1 = 0; cycle();
    chk("x0_no_stall", {16'd0, stall_cnt}, 32'd1);
    clear_inputs();

    // rs2 hazard only counts when rs2 is used
    ex_is_load = 1; ex_rd = 7; dec_rs2 = 7; dec_uses_rs2 = 0; cycle();
    dec_uses_rs2 = 1; cycle();
    clear_inputs();

    // Branch beats load-use
    br_taken = 1; br_target = 32'h0000_0103; ex_is_load = 1; ex_rd = 3; dec_rs1 = 3; cycle();
    clear_inputs();
    chk("br_pc", pc, 32'h0000_0100);
    chk("br_stall_unchanged", {16'd0, stall_cnt}, 32'd2);
    cycle();

    // Memory wait: 4 frozen MEM_WAIT cycles, then ack cycle advances
    dmem_req = 1; cycle();
    for (int i = 0; i < 4; i++) begin
      chk("mw_state", {30'd0, state}, 32'd2);
      cycle();
    end
    dmem_ack = 1; cycle();
    clear_inputs();
    chk("mw_done_state", {30'd0, state}, 32'd1);

    // Same-cycle req/ack is not a stall
    dmem_req = 1; dmem_ack = 1; cycle();
    clear_inputs();

    // Wrap 0xFFFFFFFC -> 0
    br_taken = 1; br_target = 32'hFFFF_FFFE; cycle();
    clear_inputs();
    chk("wrap_pre", pc, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_pc", pc, 32'h0);

    // Halt is permanent despite start pulses
    halt_req = 1; cycle();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      start = 1; cycle(); start = 0; cycle();
    end
    chk("halt_state", {30'd0, state}, 32'd3);
    do_reset();

    // Timeout after 15 MEM_WAIT cycles without ack
    start = 1; cycle(); start = 0;
    cycle();
    dmem_req = 1; cycle();
    repeat (14) cycle();
    chk("tmo_not_yet", {31'd0, fault}, 32'd0);
    cycle();
    chk("tmo_fault", {31'd0, fault}, 32'd1);
    chk("tmo_state", {30'd0, state}, 32'd3);
    cycle();
    clear_inputs();
    do_reset();
    chk("rst_fault", {31'd0, fault}, 32'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      clear_inputs();
      if (m_state == S_IDLE) start = ($urandom_range(0, 2) == 0);
      dec_rs1      = 5'($urandom_range(0, 3));
      dec_rs2      = 5'($urandom_range(0, 3));
      dec_uses_rs2 = 1'($urandom_range(0, 1));
      ex_rd        = 5'($urandom_range(0, 3));
      ex_is_load   = ($urandom_range(0, 2) == 0);
      br_taken     = ($urandom_range(0, 5) == 0);
      br_target    = $urandom;
      halt_req     = ($urandom_range(0, 79) == 0);
      dmem_req     = ($urandom_range(0, 3) == 0);
      dmem_ack     = ($urandom_range(0, 4) == 0);
      if ((m_state == S_HALT && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
        do_reset();
      else
        cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Central sequencing controller for the 4-stage pipeline (fetch → decode → exec/dmem → writeback). It owns the program counter and drives per-stage advance enables and bubble/flush strobes to the pipeline registers between the stages. It also arbitrates between four stall causes: data-memory wait, taken branch, halt request and load-use hazard. A small FSM handles start-up, memory wait with timeout, and halt.

## Interface
Parameters:
- BIN_DIG, 32 (from defs): data/address width.
- RESET_PC, 32'h0000_0000: PC value after reset.
- DMEM_TIMEOUT, 15: maximum cycles spent in MEM_WAIT before fault. 0 disables the timeout.

Ports:
- CLK  in  1  clock. All state updates on posedge.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  pulse; leaves IDLE.
- dec_rs1, dec_rs2  in  5 each  source registers of the instruction in decode.
- dec_uses_rs2  in  1  decode instruction reads rs2.
- halt_req  in  1  decode holds ecall/ebreak.
- ex_rd  in  5  destination register of the instruction in exec/dmem.
- ex_is_load  in  1  exec/dmem instruction is a load.
- br_taken  in  1  exec resolved a taken branch/jump.
- br_target  in  BIN_DIG  branch target.
- dmem_req  in  1  dmem stage has an access outstanding this cycle.
- dmem_ack  in  1  data memory completes the access.
- pc  out  BIN_DIG  current fetch address. Resets to RESET_PC.
- if_en, id_en, ex_en, wb_en  out  1 each  stage register advance enables. Reset value 0.
- id_flush, ex_flush  out  1 each  load a bubble (all-zero) into decode / exec register. Reset value 0.
- state  out  2  IDLE=0, RUN=1, MEM_WAIT=2, HALTED=3. Reset value IDLE.
- fault  out  1  sticky dmem timeout flag. Reset value 0.
- stall_cnt  out  16  saturating count of stalled RUN/MEM_WAIT cycles. Reset value 0.

## Operation
- Enables and flushes are combinational (Mealy) from state and inputs. pc, state, wait counter, fault and stall_cnt are registered.
- IDLE: all enables 0, pc held. start=1 → RUN. pc stays RESET_PC, so the first fetch is RESET_PC.
- RUN: exactly one action applies per cycle. Causes are checked in priority order; the first one present is taken.
  1. dmem_req & !dmem_ack: freeze. All enables 0, pc held, → MEM_WAIT, wait counter ← 0.
  2. br_taken: all enables 1, id_flush=1, ex_flush=1, pc ← {br_target[BIN_DIG-1:2], 2'b00}.
  3. halt_req: if_en=id_en=0, ex_en=wb_en=1, ex_flush=1 (older instruction drains), pc held, → HALTED.
  4. Load-use, defined as ex_is_load & ex_rd≠0 & (ex_rd==dec_rs1 | (dec_uses_rs2 & ex_rd==dec_rs2)): if_en=id_en=0, ex_en=wb_en=1, ex_flush=1, pc held. Lasts one cycle only.
  5. Normal: all enables 1, pc ← pc+4, modulo 2^BIN_DIG (wraps 0xFFFF_FFFC → 0).
- dmem_req & dmem_ack in the same cycle is not a stall. Branch, halt, load-use and normal are then evaluated as usual.
- MEM_WAIT:
  - dmem_ack=0: all enables 0. The wait counter increments. If the counter equals DMEM_TIMEOUT-1 (and DMEM_TIMEOUT≠0): → HALTED, fault ← 1.
  - dmem_ack=1: apply the RUN priority list with the dmem-stall cause masked, then → RUN (or → HALTED if halt_req wins).
- HALTED: all enables and flushes 0, pc held. Only RST exits.
- stall_cnt increments when state∈{RUN, MEM_WAIT} and if_en=0, except on the halt cycle. It saturates at 16'hFFFF.

## Timing
- Reset assertion (RST=0) asynchronously forces: state=IDLE, pc=RESET_PC, fault=0, stall_cnt=0, wait counter=0. All enables and flushes go to 0 immediately.
- Reset mid-MEM_WAIT or mid-halt: the same values apply, and no pending access is remembered.
- start → first if_en=1 in the next cycle.
- Branch penalty is exactly 2 bubbles (decode and exec flushed in the resolve cycle). The pc redirect is visible one cycle after br_taken.
- Load-use costs exactly 1 bubble. If the hazard still holds the following cycle, that is a new hazard and is stalled again.
- A memory wait of N cycles without ack freezes the pipeline for N cycles. The ack cycle itself advances.
- With DMEM_TIMEOUT=15, the fault is raised on the 15th consecutive MEM_WAIT cycle without ack; state=HALTED on the following cycle.

## Test plan
- Reset/start: RST low, then high, start pulse → pc=0, state=1 next cycle; after 3 normal cycles, pc=0x0000000C.
- Load-use: ex_is_load=1, ex_rd=5, dec_rs1=5 for one cycle → if_en=id_en=0, ex_flush=1, pc held, stall_cnt=1. Repeat with ex_rd=0 → no stall.
- Branch vs load-use in the same cycle: br_taken=1, br_target=0x103, plus a hazard → id_flush=ex_flush=1, pc=0x100 next cycle, stall_cnt unchanged.
- Memory wait: dmem_req=1 with ack delayed 4 cycles → state=2 for 4 cycles with all enables 0. On the ack cycle all enables are 1 and pc+4; state=1 next cycle.
- Timeout: dmem_req=1 with ack never returned, DMEM_TIMEOUT=15 → fault=1, state=3. Then drop RST mid-HALTED → all reset values restored.
- Wrap/halt: pc=0xFFFFFFFC on a normal cycle → pc=0. halt_req → ex_en=1, if_en=0 that cycle, then state=3 permanently despite start pulses.
